// File: rtl/gcbp_bram_read_seq_if.sv
// Signal bundle between the GCBP BRAM read sequencer, its BRAM read ports and the correlator.
// With GCBP_RD_XOR_EN defined the bundle also carries the XOR line and its popcount.
interface gcbp_bram_read_seq_if #(
    parameter int C_SHIFT_BITS = 4
);
    logic                    i_start;
    logic [1:0]              i_curr_frame_loc;
    logic [1:0]              i_prev_frame_loc;
    logic [C_SHIFT_BITS-1:0] i_vshift;
    logic                    o_bram_rd_en;
    logic [8:0]              o_bram_rd_addr_a;
    logic [8:0]              o_bram_rd_addr_b;
    logic [127:0]            i_bram_rd_data_a;
    logic [127:0]            i_bram_rd_data_b;
    logic                    o_line_valid;
    logic                    i_line_ready;
    logic [127:0]            o_curr_line;
    logic [127:0]            o_prev_line;
    logic [5:0]              o_line_idx;
    logic                    o_busy;
    logic                    o_done;
`ifdef GCBP_RD_XOR_EN
    logic [127:0]            o_xor_line;
    logic [7:0]              o_xor_popcnt;

    modport master (
        input  i_start, i_curr_frame_loc, i_prev_frame_loc, i_vshift,
        input  i_bram_rd_data_a, i_bram_rd_data_b, i_line_ready,
        output o_bram_rd_en, o_bram_rd_addr_a, o_bram_rd_addr_b,
        output o_line_valid, o_curr_line, o_prev_line, o_line_idx, o_busy, o_done,
        output o_xor_line, o_xor_popcnt
    );
    modport slave (
        output i_start, i_curr_frame_loc, i_prev_frame_loc, i_vshift,
        output i_bram_rd_data_a, i_bram_rd_data_b, i_line_ready,
        input  o_bram_rd_en, o_bram_rd_addr_a, o_bram_rd_addr_b,
        input  o_line_valid, o_curr_line, o_prev_line, o_line_idx, o_busy, o_done,
        input  o_xor_line, o_xor_popcnt
    );
`else
    modport master (
        input  i_start, i_curr_frame_loc, i_prev_frame_loc, i_vshift,
        input  i_bram_rd_data_a, i_bram_rd_data_b, i_line_ready,
        output o_bram_rd_en, o_bram_rd_addr_a, o_bram_rd_addr_b,
        output o_line_valid, o_curr_line, o_prev_line, o_line_idx, o_busy, o_done
    );
    modport slave (
        output i_start, i_curr_frame_loc, i_prev_frame_loc, i_vshift,
        output i_bram_rd_data_a, i_bram_rd_data_b, i_line_ready,
        input  o_bram_rd_en, o_bram_rd_addr_a, o_bram_rd_addr_b,
        input  o_line_valid, o_curr_line, o_prev_line, o_line_idx, o_busy, o_done
    );
`endif
endinterface

// File: rtl/gcbp_bram_read_seq.sv
// GCBP BRAM read sequencer: one 64-line pass per start, pairing curr line i with prev line i+vshift.
// Optional GCBP_RD_XOR_EN adds o_xor_line / o_xor_popcnt stored alongside each pair. C_SHIFT_BITS <= 5.
module gcbp_bram_read_seq #(
    parameter int C_BRAM_RD_LATENCY = 1,
    parameter int C_SHIFT_BITS      = 4,
    parameter int C_FRAME_STRIDE    = 128
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    gcbp_bram_read_seq_if.master bus
);
    localparam int         L      = C_BRAM_RD_LATENCY;
    localparam int         DEPTH  = L + 1;
    localparam int         PTR_W  = $clog2(DEPTH);
    localparam int         CNT_W  = $clog2(DEPTH + 1);
    localparam logic [8:0] STRIDE = 9'(C_FRAME_STRIDE);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    typedef struct packed {
        logic [5:0]   idx;
        logic [127:0] curr;
        logic [127:0] prev;
`ifdef GCBP_RD_XOR_EN
        logic [127:0] xr;
        logic [7:0]   pop;
`endif
    } entry_t;

    state_t                  state_q, state_d;
    logic [5:0]              i_q, i_d;
    logic [5:0]              last_q, last_d;
    logic [1:0]              curr_loc_q, curr_loc_d;
    logic [1:0]              prev_loc_q, prev_loc_d;
    logic [C_SHIFT_BITS-1:0] vshift_q, vshift_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [L-1:0]            tag_q, tag_d;
    logic [5:0]              tag_idx_q [L];
    logic [5:0]              tag_idx_d [L];
    entry_t                  fifo_q [DEPTH];
    entry_t                  fifo_d [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic       rd_en, push, pop, valid;
    logic [5:0] vs6, start_vs6, prev_i, first_start, last_start;
    int         inflight;
    entry_t     in_entry, head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign vs6         = {{(6-C_SHIFT_BITS){vshift_q[C_SHIFT_BITS-1]}}, vshift_q};
    assign start_vs6   = {{(6-C_SHIFT_BITS){bus.i_vshift[C_SHIFT_BITS-1]}}, bus.i_vshift};
    assign first_start = start_vs6[5] ? 6'd0 - start_vs6 : 6'd0;
    assign last_start  = start_vs6[5] ? 6'd63 : 6'd63 - start_vs6;
    assign prev_i      = i_q + vs6;

    assign valid = (count_q != '0);
    assign pop   = valid & bus.i_line_ready;
    assign push  = tag_q[L-1];

    // Credit: FIFO after this cycle's pop plus every read still in the BRAM pipe must leave room
    // for one more entry; counting the pop lets a steady ready=1 stream run at one pair per cycle.
    assign inflight = int'(count_q) - int'(pop) + $countones(tag_q);
    assign rd_en    = (state_q == S_ISSUE) && (inflight < DEPTH);

    assign tag_d[0]     = rd_en;
    assign tag_idx_d[0] = i_q;
    for (genvar gi = 1; gi < L; gi++) begin : g_tag
        assign tag_d[gi]     = tag_q[gi-1];
        assign tag_idx_d[gi] = tag_idx_q[gi-1];
    end

    always_comb begin
        in_entry      = '0;
        in_entry.idx  = tag_idx_q[L-1];
        in_entry.curr = bus.i_bram_rd_data_a;
        in_entry.prev = bus.i_bram_rd_data_b;
`ifdef GCBP_RD_XOR_EN
        in_entry.xr   = bus.i_bram_rd_data_a ^ bus.i_bram_rd_data_b;
        in_entry.pop  = 8'($countones(bus.i_bram_rd_data_a ^ bus.i_bram_rd_data_b));
`endif
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = in_entry;
        end
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        state_d    = state_q;
        i_d        = i_q;
        last_d     = last_q;
        curr_loc_d = curr_loc_q;
        prev_loc_d = prev_loc_q;
        vshift_d   = vshift_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // done_q still high means this is the done cycle, where a start is ignored.
                if (bus.i_start && !done_q) begin
                    curr_loc_d = bus.i_curr_frame_loc;
                    prev_loc_d = bus.i_prev_frame_loc;
                    vshift_d   = bus.i_vshift;
                    i_d        = first_start;
                    last_d     = last_start;
                    busy_d     = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rd_en) begin
                    if (i_q == last_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        i_d = i_q + 6'd1;
                    end
                end
            end
            S_DRAIN: begin
                if ((tag_d == '0) && (count_d == '0)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            last_q     <= '0;
            curr_loc_q <= '0;
            prev_loc_q <= '0;
            vshift_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int k = 0; k < L; k++) begin
                tag_idx_q[k] <= '0;
            end
            for (int k = 0; k < DEPTH; k++) begin
                fifo_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            last_q     <= last_d;
            curr_loc_q <= curr_loc_d;
            prev_loc_q <= prev_loc_d;
            vshift_q   <= vshift_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tag_q      <= tag_d;
            tag_idx_q  <= tag_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fifo_q     <= fifo_d;
        end
    end

    assign head = fifo_q[rd_ptr_q];

    assign bus.o_bram_rd_en     = rd_en;
    assign bus.o_bram_rd_addr_a = 9'(curr_loc_q) * STRIDE + 9'(i_q);
    assign bus.o_bram_rd_addr_b = 9'(prev_loc_q) * STRIDE + 9'(prev_i);
    assign bus.o_line_valid     = valid;
    assign bus.o_curr_line      = head.curr;
    assign bus.o_prev_line      = head.prev;
    assign bus.o_line_idx       = head.idx;
    assign bus.o_busy           = busy_q;
    assign bus.o_done           = done_q;
`ifdef GCBP_RD_XOR_EN
    assign bus.o_xor_line       = head.xr;
    assign bus.o_xor_popcnt     = head.pop;
`endif
endmodule
